// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and round-robin search helper for arb_rr4
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int CNT_W = 4;

    // Returns {found, index} of the first set bit of cand, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!result[2] && cand[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dec2to4.sv
// rtl/dec2to4.sv - 2-to-4 one-hot decoder with enable
module dec2to4 (
    input  logic [1:0] w,
    input  logic       en,
    output logic [3:0] o
);

    // One-hot decode of w, all zeros when disabled
    always_comb begin
        o = 4'b0000;
        if (en) begin
            o[w] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_rr4.sv
// rtl/arb_rr4.sv - 4-requester round-robin arbiter with bounded grant hold time
module arb_rr4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gidx,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       gidx_q, gidx_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       pick_any;
    logic [2:0]       pick_other;
    logic             own_req;

    // Next-state logic: idle pickup, hold counting, release with handover or re-grant
    always_comb begin
        state_d    = state_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        own_req    = req[gidx_q];
        pick_any   = rr_pick(req, ptr_q);
        // The current owner is masked out so a release hands over to someone else when possible
        pick_other = rr_pick(req & ~(4'b0001 << gidx_q), ptr_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gidx_d  = pick_any[1:0];
                    ptr_d   = pick_any[1:0];
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (own_req && (cnt_q < HOLD_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (pick_other[2]) begin
                    gidx_d = pick_other[1:0];
                    ptr_d  = pick_other[1:0];
                    cnt_d  = '0;
                end else if (own_req) begin
                    // Hold expired with nobody else waiting: same owner starts a fresh hold window
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset leaves ptr at 3 so requester 0 is searched first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gidx_q  <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == GRANT);
    assign gidx = gidx_q;

    dec2to4 u_gnt_dec (
        .w  (gidx_q),
        .en (busy),
        .o  (gnt)
    );

endmodule

// File: doc/arb_rr4.md
ARB_RR4 -- requirements
Module: arb_rr4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive cycles one grant is held (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, request lines; req[i] high means requester i wants the shared resource.
REQ-005 The block SHALL have port gnt, output, 4, one-hot grant; gnt[i] high means requester i owns the resource.
REQ-006 The block SHALL have port gidx, output, 2, the binary index of the current owner; it is valid only while busy is high.
REQ-007 The block SHALL have port busy, output, 1, high while any grant is active.

Function
REQ-008 The state machine SHALL have two states: IDLE (no grant) and GRANT (one owner).
REQ-009 gnt SHALL be a purely combinational 2-to-4 decode of the registered gidx, enabled by busy.
- gnt = 4'b0000 when busy = 0.
- Exactly one bit of gnt is high when busy = 1.
REQ-010 The round-robin pointer ptr (2 bits) SHALL hold the index of the last requester granted; search order is ptr+1, ptr+2, ptr+3, ptr, modulo 4.
REQ-011 In IDLE, if req != 0 at an edge:
- The block enters GRANT with gidx = first requester in search order.
- hold counter cnt is loaded with 0.
- ptr is loaded with the new gidx.
- busy and gnt rise one cycle after the req sample (latency 1).
REQ-012 In IDLE, if req == 0, the block SHALL remain in IDLE.
REQ-013 In GRANT, if req[gidx] = 1 and cnt < MAX_HOLD-1, the block SHALL keep gidx and increment cnt.
REQ-014 In GRANT, release SHALL occur when req[gidx] = 0 or cnt == MAX_HOLD-1.
- On release, if another requester (not gidx) is pending, the next owner is the first one in search order.
- Handover is back-to-back with no idle cycle; cnt is reset to 0 and ptr is updated.
REQ-015 On release with no other requester pending:
- If req[gidx] = 1 (hold expired), the same owner is re-granted with cnt reset to 0.
- Otherwise the block returns to IDLE.
REQ-016 Requests arriving or dropping in the same cycle as a release SHALL be evaluated on the req value sampled at that edge only.
REQ-017 A requester that has been granted SHALL NOT be granted again while any other requester holds its request high continuously.
- Worst-case wait is 3*MAX_HOLD + 1 cycles.
REQ-018 cnt width SHALL be 4 bits, and cnt SHALL never exceed MAX_HOLD-1.

Reset
REQ-019 While rst = 1 the block SHALL be in IDLE with outputs forced:
- gnt = 0, gidx = 0, busy = 0.
- cnt = 0, ptr = 3, so that requester 0 is searched first after reset.
REQ-020 Assertion of rst mid-grant SHALL clear gnt immediately and asynchronously.
REQ-021 After deassertion of rst, the first grant SHALL follow REQ-011 with ptr = 3.

Structure
REQ-022 A shared package arb_pkg SHALL hold:
- the state enum type (IDLE, GRANT);
- the cnt width constant (4).
REQ-023 The 2-to-4 decoder with enable SHALL be a separate sub-module dec2to4 (inputs w[1:0], en; output o[3:0]), instantiated once for gnt.
REQ-024 The next-owner search SHALL be a combinational function of req, ptr and gidx; all state (state, gidx, ptr, cnt) SHALL be registered.

Verification
REQ-025 Single request: after reset, req = 0100 held -> gnt = 0100 and gidx = 2 from cycle 1 onward; with MAX_HOLD = 4, cnt cycles 0..3 and the grant is re-granted to 2 every 4 cycles with gnt staying high.
REQ-026 Full contention: req = 1111 held, MAX_HOLD = 2 -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001, with busy = 1 throughout.
REQ-027 Early drop: owner 1 drops req after 1 cycle while req[3] = 1 -> the next edge gives gnt = 1000 with no idle gap.
REQ-028 Idle return: the sole owner drops req -> the next edge gives gnt = 0000, busy = 0, gidx retained; a new req = 0001 is granted one cycle later.
REQ-029 Reset mid-operation: rst pulsed while gnt = 0010 -> gnt = 0000 before the next clk edge; after release with req = 1111, the first grant is 0001.
REQ-030 Invariants SHALL be asserted every cycle:
- gnt is one-hot or zero;
- gnt == (busy ? 1<<gidx : 0);
- cnt <= MAX_HOLD-1.
